// File: rtl/periph_bus_pkg.sv
// Shared types and defaults for the VeSPA peripheral bus initiator.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_ADDR_LIMIT = 16;

    // Load data returned alongside a decode error.
    localparam logic [DEF_DATA_W-1:0] RSP_DATA_ON_ERR = 32'h0000_0000;

endpackage

// File: rtl/periph_bus_master.sv
// Turns one CPU valid/ready load or store into a single-cycle peripheral bus
// strobe, waits the slave read latency and returns a held valid/ready response.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int ADDR_LIMIT = DEF_ADDR_LIMIT
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_ReqValid,
    output logic              o_ReqReady,
    input  logic              i_ReqWrite,
    input  logic [ADDR_W-1:0] i_ReqAddr,
    input  logic [DATA_W-1:0] i_ReqWData,
    output logic              o_RspValid,
    input  logic              i_RspReady,
    output logic [DATA_W-1:0] o_RspData,
    output logic              o_RspErr,
    output logic              o_WEnable,
    output logic [ADDR_W-1:0] o_WAddr,
    output logic [DATA_W-1:0] o_WData,
    output logic              o_REnable,
    output logic [ADDR_W-1:0] o_RAddr,
    input  logic [DATA_W-1:0] i_RData,
    input  logic              i_Err
);

    localparam int                CNT_W      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LIMIT_ADDR = ADDR_W'(ADDR_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_wen;
    logic              r_ren;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_raddr;

    logic w_req_hs;
    logic w_rsp_hs;
    logic w_decode_err;
    logic w_wait_last;
    logic w_accept_bus;

    // r_req_ready is low in the first cycle after reset, so it gates the handshake too.
    assign w_req_hs     = i_ReqValid & r_req_ready;
    assign w_rsp_hs     = r_rsp_valid & i_RspReady;
    assign w_decode_err = (i_ReqAddr >= LIMIT_ADDR);
    assign w_wait_last  = (r_cnt == CNT_LAST);
    assign w_accept_bus = w_req_hs & ~w_decode_err;

    // State register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) begin
                    if (w_decode_err) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_STROBE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_STROBE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request direction latch and read-latency counter.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_write <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            if (w_req_hs) begin
                r_write <= i_ReqWrite;
            end
            if (r_state == ST_STROBE) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered handshake flags and bus strobes; bus address/data hold between strobes.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_waddr     <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_raddr     <= {ADDR_W{1'b0}};
        end else begin
            r_req_ready <= (w_next == ST_IDLE);
            r_rsp_valid <= (w_next == ST_RESP);
            r_wen       <= w_accept_bus & i_ReqWrite;
            r_ren       <= w_accept_bus & ~i_ReqWrite;
            if (w_accept_bus & i_ReqWrite) begin
                r_waddr <= i_ReqAddr;
                r_wdata <= i_ReqWData;
            end
            if (w_accept_bus & ~i_ReqWrite) begin
                r_raddr <= i_ReqAddr;
            end
        end
    end

    // Response capture: decode errors at acceptance, slave data on the last wait cycle.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rsp_data <= {DATA_W{1'b0}};
            r_rsp_err  <= 1'b0;
        end else if (w_req_hs & w_decode_err) begin
            r_rsp_data <= DATA_W'(RSP_DATA_ON_ERR);
            r_rsp_err  <= 1'b1;
        end else if ((r_state == ST_WAIT) && w_wait_last) begin
            r_rsp_err  <= i_Err;
            r_rsp_data <= r_write ? {DATA_W{1'b0}} : i_RData;
        end
    end

    assign o_ReqReady = r_req_ready;
    assign o_RspValid = r_rsp_valid;
    assign o_RspData  = r_rsp_data;
    assign o_RspErr   = r_rsp_err;
    assign o_WEnable  = r_wen;
    assign o_WAddr    = r_waddr;
    assign o_WData    = r_wdata;
    assign o_REnable  = r_ren;
    assign o_RAddr    = r_raddr;

endmodule
